// File: rtl/ft_cmd_bridge.sv
// ft_cmd_bridge: register-access bridge between the FT245 user-side FIFOs
// and the telemetry checker. Host commands arrive on ui_dout*, responses
// leave on ui_din*. One command is handled at a time.
//
// Optional feature: define FT_BRIDGE_TIMEOUT_EN to abort a WRITE whose data
// words stop arriving for TIMEOUT_CYCLES cycles; the bridge then answers
// with {8'hEE, 8'hFF} and performs no write.
module ft_cmd_bridge #(
    parameter logic [15:0] VERSION        = 16'h0001,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ui_dout,
    input  logic [1:0]  ui_dout_be,
    input  logic        ui_dout_empty,
    output logic        ui_dout_get,
    output logic [15:0] ui_din,
    output logic [1:0]  ui_din_be,
    output logic        ui_din_valid,
    input  logic        ui_din_full,
    input  logic [31:0] total_packets,
    input  logic [31:0] mismatch_packets,
    input  logic        okay_led,
    input  logic        link_count_okay,
    output logic        reset_counters
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WHI  = 2'd1;
    localparam logic [1:0] ST_WLO  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_ERR   = 8'hEE;

    localparam logic [7:0] ADDR_TOTAL    = 8'd0;
    localparam logic [7:0] ADDR_MISMATCH = 8'd1;
    localparam logic [7:0] ADDR_STATUS   = 8'd2;
    localparam logic [7:0] ADDR_CONTROL  = 8'd3;
    localparam logic [7:0] ADDR_SCRATCH  = 8'd4;
    localparam logic [7:0] ADDR_VERSION  = 8'd5;

    // Command/response state
    logic [1:0]  state_q, state_d;
    logic [15:0] resp_hdr_q, resp_hdr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] scratch_q, scratch_d;
    logic        rst_cnt_q, rst_cnt_d;

    // Decode helpers
    logic        accepting;
    logic        word_ok;
    logic [7:0]  hdr_op;
    logic [7:0]  hdr_addr;
    logic [7:0]  cur_addr;
    logic [31:0] rd_data;
    logic [15:0] resp_word;
    logic        tmo_hit;

    // Words are only consumed while collecting a command, never during RESP.
    assign accepting   = (state_q != ST_RESP);
    assign ui_dout_get = !ui_dout_empty && accepting;
    // A word with partial byte enables is popped but otherwise ignored.
    assign word_ok     = ui_dout_get && (ui_dout_be == 2'b11);
    assign hdr_op      = ui_dout[15:8];
    assign hdr_addr    = ui_dout[7:0];
    // During a write the header (and thus its address) sits in resp_hdr_q.
    assign cur_addr    = resp_hdr_q[7:0];

`ifdef FT_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        in_write;

    assign in_write = (state_q == ST_WHI) || (state_q == ST_WLO);

    // Count cycles since the last pop while waiting for write data; a pop
    // restarts the count at 1 so the value equals cycles elapsed.
    always_comb begin
        tmo_cnt_d = 16'd0;
        if (ui_dout_get) begin
            tmo_cnt_d = 16'd1;
        end else if (in_write) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Fire when the incremented count reaches the limit, so RESP starts
    // exactly TIMEOUT_CYCLES cycles after the last pop.
    assign tmo_hit = in_write && !ui_dout_get &&
                     ((tmo_cnt_q + 16'd1) == TIMEOUT_CYCLES);

    // Idle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [15:0] unused_timeout;

    assign tmo_hit        = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    // Register read mux, indexed by the address of the header being popped
    always_comb begin
        rd_data = 32'hDEADBEEF;
        case (hdr_addr)
            ADDR_TOTAL:    rd_data = total_packets;
            ADDR_MISMATCH: rd_data = mismatch_packets;
            ADDR_STATUS:   rd_data = {30'b0, link_count_okay, okay_led};
            ADDR_CONTROL:  rd_data = 32'h0000_0000;
            ADDR_SCRATCH:  rd_data = scratch_q;
            ADDR_VERSION:  rd_data = {16'b0, VERSION};
            default:       rd_data = 32'hDEADBEEF;
        endcase
    end

    // Command state machine: collect header and write data, perform writes,
    // then step through the response words as the transmit FIFO accepts them
    always_comb begin
        state_d    = state_q;
        resp_hdr_d = resp_hdr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        last_d     = last_q;
        scratch_d  = scratch_q;
        rst_cnt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (word_ok) begin
                    idx_d = 2'd0;
                    case (hdr_op)
                        OP_READ: begin
                            resp_hdr_d = ui_dout;
                            data_d     = rd_data;
                            last_d     = 2'd2;
                            state_d    = ST_RESP;
                        end
                        OP_WRITE: begin
                            resp_hdr_d = ui_dout;
                            last_d     = 2'd0;
                            state_d    = ST_WHI;
                        end
                        default: begin
                            resp_hdr_d = {OP_ERR, hdr_addr};
                            last_d     = 2'd0;
                            state_d    = ST_RESP;
                        end
                    endcase
                end
            end

            ST_WHI: begin
                if (word_ok) begin
                    data_d[31:16] = ui_dout;
                    state_d       = ST_WLO;
                end else if (tmo_hit) begin
                    resp_hdr_d = {OP_ERR, 8'hFF};
                    last_d     = 2'd0;
                    idx_d      = 2'd0;
                    state_d    = ST_RESP;
                end
            end

            ST_WLO: begin
                if (word_ok) begin
                    data_d[15:0] = ui_dout;
                    if (cur_addr == ADDR_CONTROL) begin
                        rst_cnt_d = ui_dout[0];
                    end else if (cur_addr == ADDR_SCRATCH) begin
                        scratch_d = {data_q[31:16], ui_dout};
                    end
                    idx_d   = 2'd0;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    resp_hdr_d = {OP_ERR, 8'hFF};
                    last_d     = 2'd0;
                    idx_d      = 2'd0;
                    state_d    = ST_RESP;
                end
            end

            ST_RESP: begin
                if (!ui_din_full) begin
                    if (idx_q == last_q) begin
                        idx_d   = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            resp_hdr_q <= 16'h0000;
            data_q     <= 32'h0000_0000;
            idx_q      <= 2'd0;
            last_q     <= 2'd0;
            scratch_q  <= 32'h0000_0000;
            rst_cnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_hdr_q <= resp_hdr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            scratch_q  <= scratch_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    // Select the response word for the current index
    always_comb begin
        resp_word = 16'h0000;
        case (idx_q)
            2'd0:    resp_word = resp_hdr_q;
            2'd1:    resp_word = data_q[31:16];
            2'd2:    resp_word = data_q[15:0];
            default: resp_word = 16'h0000;
        endcase
    end

    assign ui_din_valid   = (state_q == ST_RESP) && !ui_din_full;
    assign ui_din         = (state_q == ST_RESP) ? resp_word : 16'h0000;
    assign ui_din_be      = 2'b11;
    assign reset_counters = rst_cnt_q;

endmodule

// File: tb/tb_ft_cmd_bridge.sv
// Testbench for ft_cmd_bridge: a receive-FIFO model feeds host words, a
// scoreboard queue holds expected response words, and a monitor compares
// every word the bridge writes to the transmit side.
module tb_ft_cmd_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ui_dout;
    logic [1:0]  ui_dout_be;
    logic        ui_dout_empty;
    logic        ui_dout_get;
    logic [15:0] ui_din;
    logic [1:0]  ui_din_be;
    logic        ui_din_valid;
    logic        ui_din_full = 1'b0;
    logic [31:0] total_packets = 32'h0;
    logic [31:0] mismatch_packets = 32'h0;
    logic        okay_led = 1'b0;
    logic        link_count_okay = 1'b0;
    logic        reset_counters;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    logic [17:0] rxQ[$];
    exp_t        sbQ[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastPopCyc = 0;
    int popCount = 0;
    int rcPulses = 0;
    logic getSeen = 1'b0;
    logic prevRc = 1'b0;

    ft_cmd_bridge #(
        .VERSION        (16'h0001),
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ui_dout          (ui_dout),
        .ui_dout_be       (ui_dout_be),
        .ui_dout_empty    (ui_dout_empty),
        .ui_dout_get      (ui_dout_get),
        .ui_din           (ui_din),
        .ui_din_be        (ui_din_be),
        .ui_din_valid     (ui_din_valid),
        .ui_din_full      (ui_din_full),
        .total_packets    (total_packets),
        .mismatch_packets (mismatch_packets),
        .okay_led         (okay_led),
        .link_count_okay  (link_count_okay),
        .reset_counters   (reset_counters)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Receive FIFO model: note pops mid-cycle, retire them after the edge
    always @(negedge clk) begin
        if (rst_n && ui_dout_get) begin
            getSeen    = 1'b1;
            lastPopCyc = cyc;
            popCount++;
        end
    end

    initial begin
        ui_dout       = 16'h0;
        ui_dout_be    = 2'b00;
        ui_dout_empty = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (getSeen && rxQ.size() > 0) void'(rxQ.pop_front());
            getSeen = 1'b0;
            if (rxQ.size() > 0) begin
                {ui_dout_be, ui_dout} = rxQ[0];
                ui_dout_empty = 1'b0;
            end else begin
                ui_dout_empty = 1'b1;
            end
        end
    end

    // Monitor: compare every transmitted word against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (ui_din_valid) begin
                checkOutput("valid_while_full", {31'b0, ui_din_full}, 32'd0);
                checkOutput("pop_during_resp", {31'b0, ui_dout_get}, 32'd0);
                checkOutput("din_be", {30'b0, ui_din_be}, 32'd3);
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %h, expected none", ui_din);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("resp_word", {16'b0, ui_din}, {16'b0, e.data});
                    if (e.lat != 0)
                        checkOutput("resp_latency", cyc - lastPopCyc, e.lat);
                end
            end
            if (reset_counters) begin
                rcPulses++;
                checkOutput("rc_timing", cyc - lastPopCyc, 32'd1);
                checkOutput("rc_width", {31'b0, prevRc}, 32'd0);
            end
            prevRc = reset_counters;
        end else begin
            prevRc = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] be, input logic [15:0] w);
        tick(1);
        rxQ.push_back({be, w});
    endtask

    task automatic expectWord(input logic [15:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.lat  = lat;
        sbQ.push_back(e);
    endtask

    task automatic expectRead(input logic [15:0] hdr, input logic [31:0] val);
        expectWord(hdr, 1);
        expectWord(val[31:16], 0);
        expectWord(val[15:0], 0);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 2000; i++) begin
            if (rxQ.size() == 0 && sbQ.size() == 0) break;
            tick(1);
        end
        tick(3);
        checkOutput("drain", rxQ.size() + sbQ.size(), 32'd0);
    endtask

    task automatic doRead(input logic [15:0] hdr, input logic [31:0] val);
        expectRead(hdr, val);
        applyStimulus(2'b11, hdr);
    endtask

    task automatic doWrite(input logic [15:0] hdr, input logic [15:0] hi, input logic [15:0] lo);
        expectWord(hdr, 1);
        applyStimulus(2'b11, hdr);
        applyStimulus(2'b11, hi);
        applyStimulus(2'b11, lo);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int popBase;
        tick(3);
        checkOutput("rst_get", {31'b0, ui_dout_get}, 32'd0);
        checkOutput("rst_valid", {31'b0, ui_din_valid}, 32'd0);
        checkOutput("rst_din", {16'b0, ui_din}, 32'd0);
        checkOutput("rst_rc", {31'b0, reset_counters}, 32'd0);
        checkOutput("rst_be", {30'b0, ui_din_be}, 32'd3);
        rst_n = 1'b1;
        tick(2);

        // Basic read of total_packets
        total_packets = 32'h12345678;
        doRead(16'h0100, 32'h12345678);
        waitIdle();

        // Scratch write then read back
        doWrite(16'h0204, 16'hCAFE, 16'hF00D);
        doRead(16'h0104, 32'hCAFEF00D);
        waitIdle();

        // Control writes: only lo bit0 pulses reset_counters
        doWrite(16'h0203, 16'h0000, 16'h0001);
        waitIdle();
        doWrite(16'h0203, 16'hFFFF, 16'hFFFE);
        waitIdle();

        // Unknown opcode and version
        expectWord(16'hEE09, 1);
        applyStimulus(2'b11, 16'h7F09);
        doRead(16'h0105, 32'h00000001);
        waitIdle();

        // Remaining register map
        mismatch_packets = 32'h000000A5;
        okay_led = 1'b1;
        link_count_okay = 1'b0;
        doRead(16'h0101, 32'h000000A5);
        doRead(16'h0102, 32'h00000001);
        waitIdle();
        okay_led = 1'b0;
        link_count_okay = 1'b1;
        doRead(16'h0102, 32'h00000002);
        doRead(16'h0103, 32'h00000000);
        doRead(16'h0107, 32'hDEADBEEF);
        doWrite(16'h0200, 16'h1111, 16'h2222);
        doRead(16'h0100, 32'h12345678);
        doWrite(16'h0209, 16'h3333, 16'h4444);
        waitIdle();

        // Partial byte-enable words are discarded in every collecting state
        applyStimulus(2'b00, 16'h0104);
        expectWord(16'h0204, 1);
        applyStimulus(2'b11, 16'h0204);
        applyStimulus(2'b01, 16'h1111);
        applyStimulus(2'b11, 16'hBEEF);
        applyStimulus(2'b10, 16'h2222);
        applyStimulus(2'b11, 16'h0001);
        doRead(16'h0104, 32'hBEEF0001);
        waitIdle();

        // Back-pressure: hold full while a read response is pending
        popBase = popCount;
        ui_din_full = 1'b1;
        expectWord(16'h0100, 0);
        expectWord(16'h1234, 0);
        expectWord(16'h5678, 0);
        applyStimulus(2'b11, 16'h0100);
        doRead(16'h0101, 32'h000000A5);
        tick(2);
        total_packets = 32'hFFFFFFFF;
        tick(8);
        checkOutput("pops_while_full", popCount - popBase, 32'd1);
        ui_din_full = 1'b0;
        waitIdle();
        total_packets = 32'h12345678;

`ifdef FT_BRIDGE_TIMEOUT_EN
        // Write abandoned after the header, then after the hi word
        expectWord(16'hEEFF, 16);
        applyStimulus(2'b11, 16'h0204);
        waitIdle();
        expectWord(16'hEEFF, 16);
        applyStimulus(2'b11, 16'h0204);
        applyStimulus(2'b11, 16'h1234);
        waitIdle();
        doRead(16'h0104, 32'hBEEF0001);
        waitIdle();
`endif

        // Async reset in the middle of a write loses the command
        applyStimulus(2'b11, 16'h0204);
        applyStimulus(2'b11, 16'h5555);
        tick(3);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("midrst_valid", {31'b0, ui_din_valid}, 32'd0);
        checkOutput("midrst_rc", {31'b0, reset_counters}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        doRead(16'h0104, 32'h00000000);
        waitIdle();

        checkOutput("rc_pulses", rcPulses, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft_cmd_bridge.md
# ft_cmd_bridge

Register-access bridge between the FT245 user-side FIFO interface (`ui_dout*` / `ui_din*`) and the telemetry checker's status and control signals. It replaces the current loopback wiring with a small command protocol, so the host can read `total_packets`, `mismatch_packets` and link status, and pulse `reset_counters`. It sits directly downstream of the FT receive FIFO and upstream of the FT transmit FIFO, in the `clk_128M` domain.

## Interface
- `VERSION`, default 16'h0001: constant returned by register 5.
- `TIMEOUT_CYCLES`, default 16'd4096: idle cycles allowed between words of a WRITE. Used only with `FT_BRIDGE_TIMEOUT_EN`.
- `clk` input 1: single clock, `clk_128M` at the top level.
- `rst_n` input 1: asynchronous, active-low reset.
- `ui_dout` input 16: host-to-FPGA word. First-word-fall-through; valid whenever `!ui_dout_empty`.
- `ui_dout_be` input 2: byte enables of `ui_dout`.
- `ui_dout_empty` input 1: receive FIFO empty.
- `ui_dout_get` output 1: pops the current receive word this cycle.
- `ui_din` output 16: FPGA-to-host word.
- `ui_din_be` output 2: always 2'b11.
- `ui_din_valid` output 1: writes `ui_din` this cycle.
- `ui_din_full` input 1: transmit FIFO full.
- `total_packets` input 32: checker count. Must already be in the `clk` domain; CDC is done at the instantiating level.
- `mismatch_packets` input 32: checker count. Same domain rule as `total_packets`.
- `okay_led` input 1: checker status.
- `link_count_okay` input 1: checker status.
- `reset_counters` output 1: one-cycle pulse to the checker.

## Operation
- The header word is {opcode[15:8], addr[7:0]}.
- Opcode 8'h01, READ: response is 3 words: header echo, data[31:16], data[15:0].
- Opcode 8'h02, WRITE: followed by 2 data words, hi then lo. Response is 1 word: header echo.
- Any other opcode: response is 1 word, {8'hEE, addr}.
- Register map:
  - 0: `total_packets`, RO.
  - 1: `mismatch_packets`, RO.
  - 2: {30'b0, link_count_okay, okay_led}, RO.
  - 3: control. A write with bit0=1 pulses `reset_counters`. Reads as 0.
  - 4: scratch, RW 32-bit, reset 0.
  - 5: {16'b0, VERSION}, RO.
  - Other addresses read as 32'hDEADBEEF. Writes to them are ignored but still acked.
- Writes to RO registers are ignored and acked.
- Any word with `ui_dout_be != 2'b11` is popped and discarded in every state. It does not advance the state machine.
- A READ snapshots all 32 data bits in the cycle its header is popped, so the hi and lo halves are coherent.
- States:
  - IDLE: pop the header. READ or unknown opcode → RESP. WRITE → WHI.
  - WHI: pop the hi word → WLO.
  - WLO: pop the lo word, perform the write → RESP.
  - RESP: emit the response words (2-bit index) → IDLE.
- `ui_dout_get` = `!ui_dout_empty` && state ∈ {IDLE, WHI, WLO}. It is combinational on state and empty.
- No new word is popped while in RESP, so the bridge handles one command at a time.

## Timing
- Reset values:
  - `ui_dout_get`=0, `ui_din_valid`=0, `ui_din`=0, `reset_counters`=0.
  - State = IDLE, scratch = 0.
- `ui_din_be` is the constant 2'b11.
- Latency: header or lo word popped in cycle N → first response word has `ui_din_valid`=1 in cycle N+1, provided `!ui_din_full`.
- `ui_din_valid` is asserted only when `!ui_din_full` in that cycle. When full, the current word is held and its index does not advance.
- A 3-word READ with `ui_din_full`=0 throughout occupies N+1 to N+3. IDLE is re-entered at N+4.
- `reset_counters` is high for exactly the cycle after the WLO pop. It does not depend on `ui_din_full`.
- An async reset mid-command returns to IDLE immediately. The partial command is lost, and no response is sent for it.

## Configuration
- `FT_BRIDGE_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WHI and WLO and clears on every pop.
  - When it reaches `TIMEOUT_CYCLES`, the bridge goes to RESP and emits a single word {8'hEE, 8'hFF} instead of the ack. No write is performed.
- Undefined: WHI and WLO wait indefinitely. No counter is synthesized.

## Test plan
- Drive `total_packets`=32'h12345678, then send 16'h0100 → response words 16'h0100, 16'h1234, 16'h5678, with the first word 1 cycle after the pop.
- Send 16'h0204, 16'hCAFE, 16'hF00D → ack 16'h0204. Then send 16'h0104 → 16'h0104, 16'hCAFE, 16'hF00D.
- Send 16'h0203, 16'h0000, 16'h0001 → `reset_counters` high for exactly 1 cycle, then ack 16'h0203.
- Send 16'h7F09 → response 16'hEE09. Then send 16'h0105 → 16'h0105, 16'h0000, 16'h0001.
- Hold `ui_din_full`=1 for 10 cycles during a READ response → no `ui_din_valid` while full, all 3 words delivered in order, no pops while in RESP. Also insert a word with be=2'b01 between a header and its data → the word is discarded and the command still completes.
- With `FT_BRIDGE_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=16: send 16'h0204 only → response 16'hEEFF 16 cycles after the pop, scratch unchanged.
